// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline sequencing controller: shadow pipeline, RAW forwarding, load-use stall, jump flush
// Shadow slots are packed {v, we, ld, st}; outputs are combinational from registered state and inputs.
module hazard_ctrl #(
   parameter int JMP_BUBBLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       id_we,
   input  logic       id_ld,
   input  logic       id_st,
   input  logic       br_taken,
   input  logic [3:0] rr1,
   input  logic [3:0] rr2,
   input  logic [3:0] wr_exe,
   input  logic [3:0] wr_mem,
   output logic [1:0] dr1_src,
   output logic [1:0] dr2_src,
   output logic       stall_ld,
   output logic       stall_jmp,
   output logic       stall_dummy,
   output logic       pc_src,
   output logic       rfile_we,
   output logic       mem_we
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LD_STALL = 2'd1,
      J_FLUSH  = 2'd2
   } state_t;

   localparam int V  = 3;
   localparam int WE = 2;
   localparam int LD = 1;
   localparam int ST = 0;

   localparam logic [1:0] SRC_MEM  = 2'b00;
   localparam logic [1:0] SRC_EXE  = 2'b01;
   localparam logic [1:0] SRC_RF   = 2'b10;
   localparam logic [1:0] SRC_DMEM = 2'b11;

   localparam logic [1:0] CNT_INIT = 2'(JMP_BUBBLES - 1);

   state_t     state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic [3:0] dec_q, dec_d;
   logic [3:0] exe_q, exe_d;
   logic [3:0] mem_q, mem_d;
   logic [3:0] wb_q, wb_d;

   logic       hit_e1, hit_e2, hit_m1, hit_m2;
   logic       luh;
   logic       stall_ld_c, stall_jmp_c, pc_src_c;
   logic [1:0] sel1, sel2;

   // Younger producer (exe) wins; a load still in exe cannot forward and falls through to mem.
   function automatic logic [1:0] fwd_sel(input logic hit_e, input logic e_ld,
                                          input logic hit_m, input logic m_ld);
      if (hit_e && !e_ld) begin
         return SRC_EXE;
      end else if (hit_m) begin
         return m_ld ? SRC_DMEM : SRC_MEM;
      end else begin
         return SRC_RF;
      end
   endfunction

   assign hit_e1 = exe_q[V] & exe_q[WE] & (rr1 == wr_exe);
   assign hit_e2 = exe_q[V] & exe_q[WE] & (rr2 == wr_exe);
   assign hit_m1 = mem_q[V] & mem_q[WE] & (rr1 == wr_mem);
   assign hit_m2 = mem_q[V] & mem_q[WE] & (rr2 == wr_mem);
   assign luh    = dec_q[V] & (hit_e1 | hit_e2) & exe_q[LD];
   assign sel1   = fwd_sel(hit_e1, exe_q[LD], hit_m1, mem_q[LD]);
   assign sel2   = fwd_sel(hit_e2, exe_q[LD], hit_m2, mem_q[LD]);

   // LD_STALL re-issues the held instruction; exe holds the bubble so no new load-use can arise there.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      stall_ld_c  = 1'b1;
      stall_jmp_c = 1'b1;
      pc_src_c    = 1'b0;
      case (state_q)
         RUN: begin
            if (luh) begin
               stall_ld_c  = 1'b0;
               stall_jmp_c = 1'b0;
               state_d     = LD_STALL;
            end else if (br_taken) begin
               pc_src_c = 1'b1;
               cnt_d    = CNT_INIT;
               state_d  = J_FLUSH;
            end
         end
         LD_STALL: begin
            if (br_taken) begin
               pc_src_c = 1'b1;
               cnt_d    = CNT_INIT;
               state_d  = J_FLUSH;
            end else begin
               state_d = RUN;
            end
         end
         J_FLUSH: begin
            if (cnt_q == 2'd0) begin
               state_d = RUN;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      dec_d = dec_q;
      if (state_q == J_FLUSH) begin
         dec_d = 4'b0000;
      end else if (stall_ld_c) begin
         dec_d = {1'b1, id_we, id_ld, id_st};
      end
      exe_d = stall_ld_c ? dec_q : 4'b0000;
      mem_d = exe_q;
      wb_d  = mem_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         cnt_q   <= 2'd0;
         dec_q   <= 4'b0000;
         exe_q   <= 4'b0000;
         mem_q   <= 4'b0000;
         wb_q    <= 4'b0000;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dec_q   <= dec_d;
         exe_q   <= exe_d;
         mem_q   <= mem_d;
         wb_q    <= wb_d;
      end
   end

   // Outputs sit at their idle values while reset is held.
   assign dr1_src     = rst ? SRC_RF : sel1;
   assign dr2_src     = rst ? SRC_RF : sel2;
   assign stall_ld    = rst | stall_ld_c;
   assign stall_jmp   = rst | stall_jmp_c;
   assign stall_dummy = 1'b1;
   assign pc_src      = ~rst & pc_src_c;
   assign rfile_we    = ~rst & wb_q[V] & wb_q[WE];
   assign mem_we      = ~rst & mem_q[V] & mem_q[ST];

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl against an instruction-flow reference model
module tb_hazard_ctrl;

   localparam int JB = 2;

   localparam logic [2:0] NOP   = 3'b000;
   localparam logic [2:0] ALU   = 3'b100;
   localparam logic [2:0] LOAD  = 3'b110;
   localparam logic [2:0] STORE = 3'b001;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       id_we = 1'b0, id_ld = 1'b0, id_st = 1'b0, br_taken = 1'b0;
   logic [3:0] rr1 = '0, rr2 = '0, wr_exe = '0, wr_mem = '0;
   logic [1:0] dr1_src, dr2_src;
   logic       stall_ld, stall_jmp, stall_dummy, pc_src, rfile_we, mem_we;

   always #5 clk = ~clk;

   hazard_ctrl #(.JMP_BUBBLES(JB)) dut (
      .clk(clk), .rst(rst),
      .id_we(id_we), .id_ld(id_ld), .id_st(id_st), .br_taken(br_taken),
      .rr1(rr1), .rr2(rr2), .wr_exe(wr_exe), .wr_mem(wr_mem),
      .dr1_src(dr1_src), .dr2_src(dr2_src),
      .stall_ld(stall_ld), .stall_jmp(stall_jmp), .stall_dummy(stall_dummy),
      .pc_src(pc_src), .rfile_we(rfile_we), .mem_we(mem_we)
   );

   typedef struct packed {
      logic v;
      logic we;
      logic ld;
      logic st;
   } ins_t;

   typedef struct {
      logic [9:0] outs;
      string      tag;
   } exp_t;

   exp_t sb[$];
   ins_t m_dec = '0, m_exe = '0, m_mem = '0, m_wb = '0;
   int   flush_left = 0;
   int   checks = 0;
   int   failures = 0;

   wire [9:0] dut_outs = {dr1_src, dr2_src, stall_ld, stall_jmp, stall_dummy, pc_src, rfile_we, mem_we};

   function automatic logic [1:0] ref_sel(input logic [3:0] r, input logic [3:0] ew, input logic [3:0] mw);
      bit he, hm;
      he = m_exe.v && m_exe.we && (r == ew);
      hm = m_mem.v && m_mem.we && (r == mw);
      if (he && !m_exe.ld) return 2'b01;
      if (hm) return m_mem.ld ? 2'b11 : 2'b00;
      return 2'b10;
   endfunction

   // One clock of stimulus: predict the outputs, queue them, then advance the instruction flow.
   task automatic cycle(input logic r, input logic [2:0] cls, input logic br,
                        input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] ew, input logic [3:0] mw, input string tag);
      logic [9:0] e;
      bit         luh;
      rst = r;
      {id_we, id_ld, id_st} = cls;
      br_taken = br;
      rr1 = a; rr2 = b; wr_exe = ew; wr_mem = mw;
      luh = 1'b0;
      if (r) begin
         e = {2'b10, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      end else begin
         luh = (flush_left == 0) && m_dec.v && m_exe.v && m_exe.we && m_exe.ld &&
               ((a == ew) || (b == ew));
         e[9:8] = ref_sel(a, ew, mw);
         e[7:6] = ref_sel(b, ew, mw);
         e[5]   = !luh;
         e[4]   = !luh;
         e[3]   = 1'b1;
         e[2]   = (flush_left == 0) && !luh && br;
         e[1]   = m_wb.v && m_wb.we;
         e[0]   = m_mem.v && m_mem.st;
      end
      sb.push_back('{e, tag});
      @(posedge clk);
      if (r) begin
         m_dec = '0; m_exe = '0; m_mem = '0; m_wb = '0;
         flush_left = 0;
      end else begin
         m_wb  = m_mem;
         m_mem = m_exe;
         m_exe = luh ? ins_t'(4'b0000) : m_dec;
         if (flush_left > 0) begin
            m_dec = '0;
            flush_left--;
         end else if (!luh) begin
            m_dec = '{1'b1, cls[2], cls[1], cls[0]};
            if (br) flush_left = JB;
         end
      end
      #1;
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) cycle(1'b0, NOP, 1'b0, 4'd1, 4'd2, 4'd14, 4'd15, tag);
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            x = sb.pop_front();
            checks++;
            if (dut_outs !== x.outs) begin
               failures++;
               $display("FAIL %s: outs{dr1,dr2,sld,sjmp,sdum,pc,rfwe,mwe}=%b expected %b",
                        x.tag, dut_outs, x.outs);
            end
         end
      end
   end

   initial begin : driver
      @(posedge clk);
      #1;
      cycle(1'b1, NOP, 1'b0, 0, 0, 0, 0, "reset");
      cycle(1'b1, NOP, 1'b0, 0, 0, 0, 0, "reset");
      idle(2, "post_reset");

      // ALU r3 then ALU reading r3
      cycle(1'b0, ALU, 1'b0, 4'd1, 4'd2, 4'd14, 4'd15, "alu_prod");
      cycle(1'b0, ALU, 1'b0, 4'd1, 4'd2, 4'd14, 4'd15, "alu_cons");
      cycle(1'b0, NOP, 1'b0, 4'd3, 4'd2, 4'd3, 4'd15, "fwd_exe");
      cycle(1'b0, NOP, 1'b0, 4'd3, 4'd2, 4'd9, 4'd3, "fwd_mem");
      idle(3, "alu_drain");

      // load r5 then ALU reading r5 in rr2
      cycle(1'b0, LOAD, 1'b0, 4'd1, 4'd2, 4'd14, 4'd15, "ld_issue");
      cycle(1'b0, ALU, 1'b0, 4'd1, 4'd2, 4'd14, 4'd15, "ld_cons");
      cycle(1'b0, NOP, 1'b0, 4'd1, 4'd5, 4'd5, 4'd15, "luh_stall");
      cycle(1'b0, NOP, 1'b0, 4'd1, 4'd5, 4'd14, 4'd5, "luh_reissue");
      idle(4, "ld_wb");

      // taken jump with a store on the wrong path
      cycle(1'b0, NOP, 1'b1, 4'd1, 4'd2, 4'd14, 4'd15, "jmp_taken");
      cycle(1'b0, STORE, 1'b0, 4'd1, 4'd2, 4'd14, 4'd15, "jmp_flush1");
      cycle(1'b0, STORE, 1'b0, 4'd1, 4'd2, 4'd14, 4'd15, "jmp_flush2");
      idle(4, "jmp_drain");

      // load-use and taken jump in the same cycle
      cycle(1'b0, LOAD, 1'b0, 4'd1, 4'd2, 4'd14, 4'd15, "lj_load");
      cycle(1'b0, ALU, 1'b0, 4'd1, 4'd2, 4'd14, 4'd15, "lj_cons");
      cycle(1'b0, NOP, 1'b1, 4'd6, 4'd2, 4'd6, 4'd15, "lj_both");
      cycle(1'b0, NOP, 1'b1, 4'd6, 4'd2, 4'd14, 4'd6, "lj_jump");
      idle(5, "lj_drain");

      // both operands r7, exe ALU writes r7, mem load writes r7
      cycle(1'b0, LOAD, 1'b0, 4'd1, 4'd2, 4'd14, 4'd15, "r7_load");
      cycle(1'b0, ALU, 1'b0, 4'd1, 4'd2, 4'd14, 4'd15, "r7_alu");
      cycle(1'b0, ALU, 1'b0, 4'd1, 4'd2, 4'd14, 4'd15, "r7_cons");
      cycle(1'b0, NOP, 1'b0, 4'd7, 4'd7, 4'd7, 4'd7, "r7_both");
      idle(4, "r7_drain");

      // reset in the middle of a jump flush
      cycle(1'b0, NOP, 1'b1, 4'd1, 4'd2, 4'd14, 4'd15, "rj_taken");
      cycle(1'b0, STORE, 1'b0, 4'd1, 4'd2, 4'd14, 4'd15, "rj_flush");
      cycle(1'b1, STORE, 1'b1, 4'd1, 4'd2, 4'd14, 4'd15, "rj_reset");
      cycle(1'b0, ALU, 1'b0, 4'd1, 4'd2, 4'd14, 4'd15, "rj_after");
      cycle(1'b0, ALU, 1'b0, 4'd1, 4'd2, 4'd14, 4'd15, "rj_cons");
      cycle(1'b0, NOP, 1'b0, 4'd4, 4'd4, 4'd4, 4'd15, "rj_fwd");
      idle(3, "rj_drain");

      for (int i = 0; i < 400; i++) begin
         logic [2:0] c;
         case ($urandom_range(0, 3))
            0: c = NOP;
            1: c = ALU;
            2: c = LOAD;
            default: c = STORE;
         endcase
         cycle(($urandom_range(0, 63) == 0), c, ($urandom_range(0, 5) == 0),
               4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
               4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), "random");
      end

      repeat (3) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain: pending=%0d expected 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
